// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the pipelined MIPS core
package mips_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_t;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [5:0] OP_J = 6'b000010;
endpackage

// File: rtl/flopenrc.sv
// flopenrc: register with enable, synchronous clear to zero and async active-high reset
// ports: clk, reset (async), en (load d), clear (sync zero, wins over en), d, q
module flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clear) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, variable-latency imem request/ack fetch FSM and IF/ID register
// ports: clk, reset (async), stallD/pcsrcD/jumpD/pcbranchD from Decode,
//        imem_req/imem_addr/imem_ack/imem_rdata memory handshake,
//        pcF, instrD, pcplus4D, opD, functD, validD to Decode, imissF miss flag
module fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic        validD,
  output logic        imissF
);
  fetch_state_t state, state_n;
  logic [31:0] pc_n, ibuf, bufpc, redir_pc, target, pcplus4F;
  logic redirect, load, capture, latch_redir, clear;
  logic [32:0] ifid_q;
  assign pcplus4F = pcF + 32'd4;
  // Decode holds a bubble while draining, so its branch inputs are meaningless then
  assign redirect = (pcsrcD | jumpD) & ~stallD & (state != DRAIN);
  assign target = jumpD ? {pcplus4D[31:28], instrD[25:0], 2'b00} : pcbranchD;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_n;
  always_comb begin
    state_n = state;
    pc_n = pcF;
    load = 1'b0;
    capture = 1'b0;
    latch_redir = 1'b0;
    case (state)
      FETCH:
        if (imem_ack) begin
          if (redirect) pc_n = target;
          else if (stallD) begin
            capture = 1'b1;
            state_n = HOLD;
          end else begin
            load = 1'b1;
            pc_n = pcplus4F;
          end
        end else if (redirect) begin
          latch_redir = 1'b1;
          state_n = DRAIN;
        end
      HOLD:
        if (!stallD) begin
          state_n = FETCH;
          pc_n = redirect ? target : pcplus4F;
          load = ~redirect;
        end
      DRAIN:
        if (imem_ack) begin
          state_n = FETCH;
          pc_n = redir_pc;
        end
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pcF <= RESET_PC;
      ibuf <= 32'h0;
      bufpc <= 32'h0;
      redir_pc <= 32'h0;
    end else begin
      pcF <= pc_n;
      if (capture) begin
        ibuf <= imem_rdata;
        bufpc <= pcplus4F;
      end
      if (latch_redir) redir_pc <= target;
    end
  assign imem_req = ~reset & (state != HOLD);
  assign imem_addr = pcF;
  assign imissF = (state == FETCH & ~imem_ack) | (state == DRAIN);
  // a non-stalled Decode that is not loading a real word sees a bubble; pcplus4D is only loaded with real words
  assign clear = ~stallD & ~load;
  flopenrc #(.WIDTH(33)) ifid_instr (
    .clk(clk), .reset(reset), .en(load), .clear(clear),
    .d({1'b1, state == HOLD ? ibuf : imem_rdata}), .q(ifid_q)
  );
  flopenrc #(.WIDTH(32)) ifid_pc (
    .clk(clk), .reset(reset), .en(load), .clear(1'b0),
    .d(state == HOLD ? bufpc : pcplus4F), .q(pcplus4D)
  );
  assign validD = ifid_q[32];
  assign instrD = ifid_q[31:0];
  assign opD = instrD[31:26];
  assign functD = instrD[5:0];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a queue-based reference model
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  logic clk = 1'b0;
  logic reset, stallD, pcsrcD, jumpD, imem_ack, imem_req, validD, imissF;
  logic [31:0] pcbranchD, imem_addr, imem_rdata, pcF, instrD, pcplus4D;
  logic [5:0] opD, functD;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic m_valid;
  logic [63:0] held[$];
  logic [31:0] drain_to[$];
  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stallD(stallD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .pcbranchD(pcbranchD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pcF(pcF), .instrD(instrD),
    .pcplus4D(pcplus4D), .opD(opD), .functD(functD), .validD(validD), .imissF(imissF)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction
  assign imem_rdata = mem_word(imem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = RPC;
    m_instr = 32'h0;
    m_pc4 = 32'h0;
    m_valid = 1'b0;
    held.delete();
    drain_to.delete();
  endtask
  task automatic bubble();
    m_instr = 32'h0;
    m_valid = 1'b0;
  endtask
  task automatic step(input logic st, input logic br, input logic jp, input logic [31:0] tgt, input logic ack);
    logic redir;
    logic [31:0] target, rd;
    chk("pcF", pcF, m_pc);
    chk("instrD", instrD, m_instr);
    chk("pcplus4D", pcplus4D, m_pc4);
    chk("validD", validD, m_valid);
    chk("opD", opD, m_instr[31:26]);
    chk("functD", functD, m_instr[5:0]);
    stallD = st;
    pcsrcD = br;
    jumpD = jp;
    pcbranchD = tgt;
    imem_ack = ack;
    #1;
    chk("imem_req", imem_req, held.size() == 0);
    if (held.size() == 0) chk("imem_addr", imem_addr, m_pc);
    chk("imissF", imissF, drain_to.size() != 0 || (held.size() == 0 && !ack));
    rd = mem_word(m_pc);
    redir = (br | jp) & ~st;
    target = jp ? {m_pc4[31:28], m_instr[25:0], 2'b00} : tgt;
    if (drain_to.size() != 0) begin
      if (!st) bubble();
      if (ack) m_pc = drain_to.pop_front();
    end else if (held.size() != 0) begin
      if (!st) begin
        if (redir) begin
          m_pc = target;
          bubble();
        end else begin
          {m_instr, m_pc4} = held[0];
          m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
        held.delete();
      end
    end else if (ack) begin
      if (redir) begin
        m_pc = target;
        bubble();
      end else if (st) held.push_back({rd, m_pc + 32'd4});
      else begin
        m_instr = rd;
        m_pc4 = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (redir) begin
      drain_to.push_back(target);
      bubble();
    end else if (!st) bubble();
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b0;
    stallD = 1'b0;
    pcsrcD = 1'b0;
    jumpD = 1'b0;
    pcbranchD = 32'h0;
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("reset_pcF", pcF, RPC);
    chk("reset_validD", validD, 1'b0);
    chk("reset_instrD", instrD, 32'h0);
    chk("reset_pcplus4D", pcplus4D, 32'h0);
    chk("reset_req", imem_req, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 32'h40, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    chk("drain_reset_pcF", pcF, RPC);
    chk("drain_reset_validD", validD, 1'b0);
    chk("drain_reset_req", imem_req, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 800; i++)
      step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(9) == 0,
           {$urandom_range(32'h3FFF_FFFF), 2'b00}, $urandom_range(2) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
